// File: rtl/count_seq_ctrl_if.sv
// Command and status bundle for count_seq_ctrl.
// master: the block issuing commands; slave: the sequencer itself.
interface count_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_limit;
    logic [REPS_W-1:0] cmd_reps;
    logic              cmd_periodic;
    logic              hold;
    logic              abort;
    logic [WIDTH-1:0]  count;
    logic [REPS_W-1:0] rep_cnt;
    logic              tick;
    logic              done;
    logic              busy;

    modport master (
        output cmd_valid, cmd_limit, cmd_reps, cmd_periodic, hold, abort,
        input  cmd_ready, count, rep_cnt, tick, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_limit, cmd_reps, cmd_periodic, hold, abort,
        output cmd_ready, count, rep_cnt, tick, done, busy
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Command-driven sequencer around a WIDTH-bit period counter.
// Accepts (limit, reps, periodic), then runs limit+1-cycle periods,
// pulsing tick at every wrap and done at the end of a one-shot sequence.
module count_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    count_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [WIDTH-1:0]  limit_q;
    logic [REPS_W-1:0] reps_q;
    logic              periodic_q;
    logic [WIDTH-1:0]  count_q;
    logic [REPS_W-1:0] rep_q;
    logic [REPS_W-1:0] rep_inc;
    logic              tick_q;
    logic              done_q;
    logic              busy_q;

    // Completed-period count after the wrap being taken; wraps naturally.
    assign rep_inc = rep_q + REPS_W'(1);

    // Only IDLE takes commands; decoded straight from the state register.
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.count     = count_q;
    assign bus.rep_cnt   = rep_q;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

    // Sequencer state, command latch, period counter and pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            limit_q    <= '0;
            reps_q     <= REPS_W'(1);
            periodic_q <= 1'b0;
            count_q    <= '0;
            rep_q      <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below reads the
            // pre-edge values; these defaults make tick/done single-cycle pulses.
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        limit_q    <= bus.cmd_limit;
                        reps_q     <= (bus.cmd_reps == '0) ? REPS_W'(1) : bus.cmd_reps;
                        periodic_q <= bus.cmd_periodic;
                        count_q    <= '0;
                        rep_q      <= '0;
                        busy_q     <= 1'b1;
                        if (bus.cmd_limit == '0 && !bus.cmd_periodic) begin
                            // Zero-length one-shot: finish at once, no tick.
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        count_q <= '0;
                        rep_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (bus.hold) begin
                        // Frozen: state, count and rep_cnt keep their values.
                    end else if (count_q != limit_q) begin
                        count_q <= count_q + WIDTH'(1);
                    end else begin
                        count_q <= '0;
                        rep_q   <= rep_inc;
                        tick_q  <= 1'b1;
                        if (!periodic_q && rep_inc == reps_q) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: stimulus pushes the expected output
// snapshot for chosen cycles; a negedge monitor pops and compares, and in
// every other cycle requires tick and done to be low.
module tb_count_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    typedef struct {
        int          cyc;
        logic [11:0] v;     // {count, rep_cnt, tick, done, busy, cmd_ready}
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [11:0] act;

    count_seq_ctrl_if #(.WIDTH(4), .REPS_W(4)) bus ();

    count_seq_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want_v);
        n_total++;
        if (actual === want_v) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, actual, want_v);
    endtask

    function automatic void want(input int c, input int cnt, input int rep, input bit t,
                                 input bit d, input bit b, input bit r, input string nm);
        exp_t x;
        logic [31:0] cv = cnt;
        logic [31:0] rv = rep;
        x.cyc  = c;
        x.v    = {cv[3:0], rv[3:0], t, d, b, r};
        x.name = nm;
        sb.push_back(x);
    endfunction

    // Monitor: compare scheduled snapshots, otherwise forbid pulses.
    always @(negedge clk) begin
        if (cyc > 0) begin
            act = {bus.count, bus.rep_cnt, bus.tick, bus.done, bus.busy, bus.cmd_ready};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_total++;
                $display("FAIL %s missed snapshot at cyc=%0d want=%h", e.name, e.cyc, e.v);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check(e.name, {20'b0, act}, {20'b0, e.v});
            end else begin
                check("no_pulse", {30'b0, bus.tick, bus.done}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a command for one edge while the DUT is known to be IDLE.
    task automatic cmd(input int lim, input int reps, input bit per, output int e_out);
        logic [31:0] lv = lim;
        logic [31:0] rv = reps;
        bus.cmd_valid    = 1'b1;
        bus.cmd_limit    = lv[3:0];
        bus.cmd_reps     = rv[3:0];
        bus.cmd_periodic = per;
        step();
        e_out = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        reset            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_limit    = '0;
        bus.cmd_reps     = '0;
        bus.cmd_periodic = 1'b0;
        bus.hold         = 1'b0;
        bus.abort        = 1'b0;

        // Power-on reset state.
        want(3, 0, 0, 0, 0, 0, 1, "reset_state");
        run(3);
        reset = 1'b1;

        // Reset in the middle of a periodic run.
        cmd(7, 0, 1, e0);
        want(e0,     0, 0, 0, 0, 1, 0, "rst_run_start");
        want(e0 + 4, 4, 0, 0, 0, 1, 0, "rst_run_cnt4");
        want(e0 + 7, 0, 0, 0, 0, 0, 1, "rst_mid_run");
        want(e0 + 8, 0, 0, 0, 0, 0, 1, "rst_stays_idle");
        run(4);
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        run(1);

        // One-shot limit=3 reps=2.
        cmd(3, 2, 0, e0);
        want(e0, 0, 0, 0, 0, 1, 0, "os_start");
        for (int k = 1; k <= 3; k++) want(e0 + k, k, 0, 0, 0, 1, 0, "os_p1");
        want(e0 + 4, 0, 1, 1, 0, 1, 0, "os_tick1");
        for (int k = 1; k <= 3; k++) want(e0 + 4 + k, k, 1, 0, 0, 1, 0, "os_p2");
        want(e0 + 8, 0, 2, 1, 1, 1, 0, "os_tick2_done");
        want(e0 + 9, 0, 2, 0, 0, 0, 1, "os_idle");
        run(10);

        // Periodic limit=2, abort after 7 ticks.
        cmd(2, 0, 1, e0);
        for (int k = 1; k <= 7; k++) want(e0 + 3 * k, 0, k, 1, 0, 1, 0, "per_tick");
        want(e0 + 22, 1, 7, 0, 0, 1, 0, "per_pre_abort");
        want(e0 + 23, 0, 0, 0, 0, 0, 1, "per_abort");
        run(22);
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;
        run(1);

        // Hold for 5 cycles at count=2 delays the tick by 5.
        cmd(4, 1, 0, e0);
        want(e0 + 2,  2, 0, 0, 0, 1, 0, "hold_at2");
        want(e0 + 5,  2, 0, 0, 0, 1, 0, "hold_mid");
        want(e0 + 7,  2, 0, 0, 0, 1, 0, "hold_end");
        want(e0 + 8,  3, 0, 0, 0, 1, 0, "hold_resume");
        want(e0 + 10, 0, 1, 1, 1, 1, 0, "hold_tick_done");
        want(e0 + 11, 0, 1, 0, 0, 0, 1, "hold_idle");
        run(2);
        bus.hold = 1'b1;
        run(5);
        bus.hold = 1'b0;
        run(4);

        // Hold on the terminal cycle suppresses the wrap.
        cmd(4, 1, 0, e0);
        want(e0 + 4, 4, 0, 0, 0, 1, 0, "thold_at4");
        want(e0 + 5, 4, 0, 0, 0, 1, 0, "thold_nowrap");
        want(e0 + 6, 0, 1, 1, 1, 1, 0, "thold_wrap");
        want(e0 + 7, 0, 1, 0, 0, 0, 1, "thold_idle");
        run(4);
        bus.hold = 1'b1;
        run(1);
        bus.hold = 1'b0;
        run(2);

        // limit=0 one-shot: done with no tick.
        cmd(0, 1, 0, e0);
        want(e0,     0, 0, 0, 1, 1, 0, "l0_done");
        want(e0 + 1, 0, 0, 0, 0, 0, 1, "l0_idle");
        run(1);

        // reps=0 behaves as reps=1.
        cmd(1, 0, 0, e0);
        want(e0 + 1, 1, 0, 0, 0, 1, 0, "r0_cnt1");
        want(e0 + 2, 0, 1, 1, 1, 1, 0, "r0_done");
        want(e0 + 3, 0, 1, 0, 0, 0, 1, "r0_idle");
        run(3);

        // limit=15 periodic: 16 periods, rep_cnt wraps 15->0, no done.
        cmd(15, 0, 1, e0);
        want(e0 + 15, 15, 0, 0, 0, 1, 0, "l15_cnt15");
        for (int k = 1; k <= 16; k++) want(e0 + 16 * k, 0, k % 16, 1, 0, 1, 0, "l15_tick");
        want(e0 + 257, 0, 0, 0, 0, 0, 1, "l15_abort");
        run(256);
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;

        // limit=0 periodic: tick every cycle.
        cmd(0, 0, 1, e0);
        for (int k = 1; k <= 4; k++) want(e0 + k, 0, k, 1, 0, 1, 0, "l0p_tick");
        want(e0 + 5, 0, 0, 0, 0, 0, 1, "l0p_abort");
        run(4);
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;

        // cmd_valid held through RUN/DONE; abort high in IDLE is ignored.
        cmd(1, 1, 0, e0);
        bus.cmd_valid    = 1'b1;
        bus.cmd_limit    = 4'd2;
        bus.cmd_reps     = 4'd1;
        bus.cmd_periodic = 1'b0;
        want(e0 + 2, 0, 1, 1, 1, 1, 0, "hs_first_done");
        want(e0 + 3, 0, 1, 0, 0, 0, 1, "hs_not_in_done");
        want(e0 + 4, 0, 0, 0, 0, 1, 0, "hs_accept");
        want(e0 + 5, 1, 0, 0, 0, 1, 0, "hs_second_cnt1");
        want(e0 + 7, 0, 1, 1, 1, 1, 0, "hs_second_done");
        want(e0 + 8, 0, 1, 0, 0, 0, 1, "hs_idle");
        run(3);
        bus.abort = 1'b1;
        run(1);
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        run(4);

        run(2);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
